// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_STALL = 2'd2
  } arb_state_e;

  localparam int unsigned BURST_LEN_DEF = 4;

  // Index width that stays legal when a count collapses to a single entry.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority search: first asserted request at or above ptr, with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [idx_w(NUM_REQ)-1:0]   ptr,
  output logic [idx_w(NUM_REQ)-1:0]   idx,
  output logic                        any
);

  localparam int unsigned IW = idx_w(NUM_REQ);

  always_comb begin
    int unsigned j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (i + 32'(ptr)) % NUM_REQ;
      if (!any && req[IW'(j)]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/global_define.sv
// Project-wide width macros shared by the FIFO datapath blocks.
`ifndef GLOBAL_DEFINE_SV
`define GLOBAL_DEFINE_SV

`define DATA_WIDTH 8
`define FIFO_WIDTH 8

`endif

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ producers with round-robin,
// burst-limited grants and a registered write stage.
`include "global_define.sv"

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ready,
  input  logic                          full,
  input  logic                          p_full,
  input  logic                          overflow,
  output logic                          wr_enb,
  output logic [DATA_WIDTH-1:0]         fifo_in,
  output logic [idx_w(NUM_REQ)-1:0]     owner,
  output logic                          busy,
  output logic                          err_ovf
);

  localparam int unsigned IW = idx_w(NUM_REQ);
  localparam int unsigned CW = idx_w(BURST_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  arb_state_e state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_enb_q, wr_enb_d;
  logic [DATA_WIDTH-1:0] fifo_in_q, fifo_in_d;
  logic                  err_ovf_q, err_ovf_d;

  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  req_own;
  logic                  room;
  logic                  accept;
  logic [IW-1:0]         next_ptr;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req(req),
    .ptr(rr_ptr_q),
    .idx(pick_idx),
    .any(pick_any)
  );

  // p_full already withholds ready, so the word registered this cycle
  // always lands in one of the reserved free entries.
  always_comb begin
    req_own  = req[owner_q];
    room     = !full && !p_full;
    accept   = (state_q == ST_GRANT) && req_own && room;
    next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    ready    = '0;
    if ((state_q == ST_GRANT) && room) begin
      ready[owner_q] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    wr_enb_d  = accept;
    fifo_in_d = accept ? sel_data : fifo_in_q;
    err_ovf_d = err_ovf_q | overflow;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!req_own) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (!req_own) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end else if (room) begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      wr_enb_q  <= 1'b0;
      fifo_in_q <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      wr_enb_q  <= wr_enb_d;
      fifo_in_q <= fifo_in_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign wr_enb  = wr_enb_q;
  assign fifo_in = fifo_in_q;
  assign owner   = owner_q;
  assign busy    = (state_q != ST_IDLE);
  assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a transaction-level grant model predicts
// accepted words; a separate monitor checks every FIFO write against them.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ready;
  logic          full, p_full, overflow;
  logic          wr_enb;
  logic [DW-1:0] fifo_in;
  logic [1:0]    owner;
  logic          busy, err_ovf;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(N),
    .DATA_WIDTH(DW),
    .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ready(ready),
    .full(full), .p_full(p_full), .overflow(overflow), .wr_enb(wr_enb),
    .fifo_in(fifo_in), .owner(owner), .busy(busy), .err_ovf(err_ovf)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
  } exp_t;
  exp_t q[$];

  bit     mon_en = 1'b0;
  int     wr_total = 0;
  int     first_wr = -1;
  bit     hist[int];
  int     step_cyc;
  bit     prev_busy = 1'b0;
  int     glog[$];

  // Reference model: who holds the port, how many words it has delivered,
  // whether it is waiting on FIFO room, and where the next search starts.
  int m_holder = -1;
  int m_words  = 0;
  int m_ptr    = 0;
  bit m_wait   = 1'b0;
  bit m_err    = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_words  = 0;
    m_ptr    = 0;
    m_wait   = 1'b0;
    m_err    = 1'b0;
    prev_busy = 1'b0;
    q.delete();
  endtask

  task automatic release_grant();
    m_ptr    = (m_holder + 1) % N;
    m_holder = -1;
  endtask

  task automatic step(input logic [N-1:0] r, input bit f, input bit pf, input bit ov);
    logic [N-1:0] er;
    bit roomy;
    bit found;
    exp_t e;
    @(negedge clk);
    step_cyc = cyc;
    req = r; full = f; p_full = pf; overflow = ov;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    #1;
    roomy = !f && !pf;
    er = '0;
    if (m_holder >= 0 && !m_wait && roomy) er[m_holder] = 1'b1;
    check("ready", ready, er);
    check("busy", busy, (m_holder >= 0));
    if (m_holder >= 0) check("owner", owner, m_holder);
    check("err_ovf", err_ovf, m_err);
    if (busy && !prev_busy) glog.push_back(int'(owner));
    prev_busy = busy;

    if (ov) m_err = 1'b1;
    if (m_holder < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && r[c]) begin
          m_holder = c;
          found = 1'b1;
        end
      end
      m_words = 0;
      m_wait  = 1'b0;
    end else if (!r[m_holder]) begin
      release_grant();
    end else if (m_wait) begin
      if (roomy) m_wait = 1'b0;
    end else if (!roomy) begin
      m_wait = 1'b1;
    end else begin
      e.data  = req_data[m_holder*DW +: DW];
      e.stamp = cyc;
      q.push_back(e);
      m_words++;
      if (m_words == BL) release_grant();
    end
  endtask

  // Monitor: every presented write must match the oldest predicted word,
  // and a predicted word must appear exactly one cycle after its accept.
  always @(negedge clk) begin
    #3;
    if (mon_en) begin
      hist[cyc] = wr_enb;
      if (wr_enb === 1'b1) begin
        wr_total++;
        if (first_wr < 0) first_wr = cyc;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got data %0h expected no write (cycle %0d)", fifo_in, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("fifo_in", fifo_in, e.data);
          check("write_latency", cyc - e.stamp, 1);
        end
      end else if (q.size() > 0 && q[0].stamp < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_write: got wr_enb %0b expected data %0h (cycle %0d)", wr_enb, q[0].data, cyc);
        void'(q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b0;
    req = '0; full = 1'b0; p_full = 1'b0; overflow = 1'b0;
    #1;
    check("rst_wr_enb", wr_enb, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_owner", owner, 0);
    check("rst_fifo_in", fifo_in, 0);
    check("rst_err_ovf", err_ovf, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    mon_en = 1'b1;
  endtask

  initial begin
    int c0, base, ones;
    logic [DW-1:0] d_prev;
    logic [N-1:0] rr;

    rst = 1'b0; req = '0; req_data = '0;
    full = 1'b0; p_full = 1'b0; overflow = 1'b0;
    do_reset();

    // Lone requester 2: grant next cycle, first write two cycles after req.
    first_wr = -1;
    step(4'b0100, 0, 0, 0); c0 = step_cyc;
    step(4'b0100, 0, 0, 0);
    check("solo_owner", owner, 2);
    d_prev = req_data[2*DW +: DW];
    step(4'b0100, 0, 0, 0);
    check("solo_wr_enb", wr_enb, 1);
    check("solo_fifo_in", fifo_in, d_prev);
    repeat (3) step(4'b0000, 0, 0, 0);
    check("solo_first_wr_latency", first_wr - c0, 2);

    // All four requesting: rotating bursts of BL words with one idle gap.
    do_reset();
    glog.delete();
    step(4'b1111, 0, 0, 0); c0 = step_cyc;
    repeat (21) step(4'b1111, 0, 0, 0);
    repeat (4) step(4'b0000, 0, 0, 0);
    check("rr_grant_count", glog.size(), 5);
    if (glog.size() == 5) begin
      for (int i = 0; i < 5; i++) check("rr_owner_seq", glog[i], i % N);
    end
    ones = 0;
    for (int c = c0 + 2; c <= c0 + 21; c++) if (hist.exists(c) && hist[c]) ones++;
    check("rr_write_density", ones, 16);

    // Back-pressure: p_full after owner 1's second word, then resume.
    do_reset();
    base = wr_total;
    step(4'b0010, 0, 0, 0);
    step(4'b0010, 0, 0, 0);
    step(4'b0010, 0, 0, 0);
    step(4'b0010, 0, 1, 0);
    check("stall_ready_edge", ready, 0);
    repeat (3) begin
      step(4'b0010, 0, 1, 0);
      check("stall_ready", ready, 0);
      check("stall_busy", busy, 1);
    end
    step(4'b0010, 0, 0, 0);
    check("stall_no_write", wr_total - base, 2);
    step(4'b0010, 0, 0, 0);
    step(4'b0010, 0, 0, 0);
    step(4'b0000, 0, 0, 0);
    check("stall_done_idle", busy, 0);
    repeat (2) step(4'b0000, 0, 0, 0);
    check("stall_total_words", wr_total - base, 4);

    // Owner 3 drops after one word; search restarts at 0.
    do_reset();
    step(4'b1000, 0, 0, 0);
    step(4'b1000, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    check("drop_idle", busy, 0);
    step(4'b0011, 0, 0, 0);
    check("drop_next_owner", owner, 0);
    check("drop_next_busy", busy, 1);
    repeat (6) step(4'b0000, 0, 0, 0);

    // Overflow pulse makes err_ovf sticky.
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 0);
    check("ovf_set", err_ovf, 1);
    repeat (5) step(4'b0000, 0, 0, 0);
    check("ovf_held", err_ovf, 1);

    // Asynchronous reset in the middle of a burst.
    step(4'b1111, 0, 0, 0);
    step(4'b1111, 0, 0, 0);
    step(4'b1111, 0, 0, 0);
    #1;
    check("pre_rst_wr_enb", wr_enb, 1);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("async_rst_wr_enb", wr_enb, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", ready, 0);
    check("async_rst_err_ovf", err_ovf, 0);
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // Randomized traffic with sticky-ish requests and random FIFO pressure.
    rr = '0;
    repeat (600) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) rr[i] = ~rr[i];
      step(rr, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), 1'b0);
    end
    repeat (8) step(4'b0000, 0, 0, 0);
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Parameters
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of producers sharing the FIFO write port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default `DATA_WIDTH: FIFO word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 4: maximum words accepted per grant.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state on posedge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: producer i holds a valid word.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: slice i is producer i's word.
REQ-008 The block SHALL have port ready, output, NUM_REQ bits: producer i's word is taken this cycle when req[i] is also high.
REQ-009 The block SHALL have ports full, p_full and overflow, each input, 1 bit: FIFO status flags.
REQ-010 The block SHALL have port wr_enb, output, 1 bit: FIFO write enable, registered.
REQ-011 The block SHALL have port fifo_in, output, DATA_WIDTH bits: FIFO write data, registered.
REQ-012 The block SHALL have port owner, output, clog2(NUM_REQ) bits: index of the current grant holder.
REQ-013 The block SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-014 The block SHALL have port err_ovf, output, 1 bit: sticky, set by overflow.

Function
REQ-015 The FSM SHALL have the states IDLE, GRANT and STALL.
REQ-016 In IDLE with any req high, the block SHALL move to GRANT, with owner = first i with req[i]=1 searching upward from rr_ptr with wrap, and burst count cnt=0.
REQ-017 ready[i] SHALL be (state==GRANT) && (owner==i) && !full && !p_full, combinationally, and SHALL be 0 for all other i.
REQ-018 On an accept (req[owner] && ready[owner]), the block SHALL drive wr_enb=1 and fifo_in=req_data[owner] in the next cycle, and cnt SHALL increment; otherwise wr_enb SHALL be 0 next cycle.
REQ-019 In GRANT, an accept with cnt==BURST_LEN-1, or req[owner]==0, SHALL cause a move to IDLE with rr_ptr=(owner+1) mod NUM_REQ.
REQ-020 In GRANT, (full || p_full) with req[owner]==1 SHALL cause a move to STALL; cnt and owner SHALL be held.
REQ-021 In STALL, !full && !p_full SHALL cause a return to GRANT; req[owner]==0 SHALL cause a move to IDLE with rr_ptr advanced as in REQ-019; drop takes priority.
REQ-022 The FIFO SHALL assert p_full with at least 2 free entries, so the one-cycle registered write never overflows.
REQ-023 err_ovf SHALL set on any cycle with overflow=1 and clear only on reset.
REQ-024 There SHALL be at most one accept per cycle, so at most one wr_enb pulse per cycle.
REQ-025 A requester lowering req mid-burst SHALL forfeit the remaining burst; it SHALL receive no further ready until re-arbitrated.

Reset
REQ-026 rst low SHALL asynchronously force: state=IDLE, rr_ptr=0, cnt=0, owner=0, wr_enb=0, fifo_in=0, err_ovf=0; ready and busy therefore 0.
REQ-027 Reset mid-burst SHALL drop the in-flight registered word; no write is issued.
REQ-028 The first arbitration after reset release SHALL start searching at requester 0.

Structure
REQ-029 The FSM state enum, and a BURST_LEN default constant, SHALL reside in a shared package, fifo_arb_pkg; DATA_WIDTH and FIFO_WIDTH SHALL stay in global_define.sv.
REQ-030 The round-robin priority search SHALL be one sub-module, rr_pick (inputs req and ptr, outputs idx and any).

Verification
REQ-031 The bench SHALL cover: req=4'b1111 held, BURST_LEN=4 -> owner sequence 0,1,2,3,0; 4 writes each; wr_enb continuous except at the IDLE cycle between grants.
REQ-032 The bench SHALL cover: only req[2]=1 after reset -> owner=2 within 1 cycle; first wr_enb 2 cycles after req rises; fifo_in=req_data[2].
REQ-033 The bench SHALL cover: p_full rises after owner 1's second word -> STALL, ready=0, no wr_enb; p_full falls -> exactly 2 more words, then IDLE.
REQ-034 The bench SHALL cover: owner 3 drops req after 1 word -> IDLE next cycle, rr_ptr=0, next owner is the lowest pending index >=0.
REQ-035 The bench SHALL cover: rst low mid-burst with wr_enb=1 -> wr_enb=0 and busy=0 immediately, with no clock edge required.
REQ-036 The bench SHALL cover: overflow pulsed 1 cycle -> err_ovf=1 and held until rst.
